and_n2t: RTL and testbench
==========================

Name: and_n2t

Overview:
- Bitwise two-input AND gate, the Nand2Tetris Chapter 1 "And" primitive, widened by a parameter.
- Provides a zero-latency combinational output `out` plus a registered, reset-able copy with small status and reduction outputs.
- Used as a leaf gate in higher-level logic (Mux, ALU) and as a pipelined AND stage where timing requires a register.

Parameters:
- WIDTH, 1, bit width of `a`, `b`, `out` and `out_q`.
- CNT_W, $clog2(WIDTH+1), width of `ones_q`. Derived; do not override.

Ports:
- clk  input  1  single clock, rising-edge active.
- rst  input  1  synchronous reset, active-high.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out  output  WIDTH  combinational `a & b`.
- out_q  output  WIDTH  registered `a & b`.
- all_q  output  1  registered reduction AND of `a & b` (all result bits 1).
- any_q  output  1  registered reduction OR of `a & b` (any result bit 1).
- ones_q  output  CNT_W  registered population count of `a & b`.
- valid_q  output  1  high when the registered outputs hold a sampled result.

Port declaration order in RTL:
- Order is fixed as a, b, out, then clk, rst, then the registered outputs.
- A 3-port positional instance `(a, b, out)` therefore elaborates and behaves as a plain AND gate.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
- Combinational path:
  - `out = a & b`, bit by bit, with zero cycle latency.
  - `out` never depends on clk or rst. It must be correct with clk/rst unconnected and while rst is high.
  - `out` must settle within a single simulation time step (no #delays in RTL).
- Truth table per bit:
  - 0,0 -> 0
  - 0,1 -> 0
  - 1,0 -> 0
  - 1,1 -> 1
- Registered path, on each rising clk edge:
  - If rst = 1: `out_q`=0, `all_q`=0, `any_q`=0, `ones_q`=0, `valid_q`=0.
  - Else:
    - `out_q` <= `a & b`
    - `all_q` <= &(a & b)
    - `any_q` <= |(a & b)
    - `ones_q` <= number of 1 bits in (a & b)
    - `valid_q` <= 1
- Latency of the registered path: exactly 1 cycle from input sample to output.
- Reset mid-operation:
  - Registered outputs clear on the first rising edge with rst high.
  - `valid_q` returns to 1 on the first edge after rst falls.
- Reset and input change together: reset wins. Inputs are ignored by the registers while rst = 1.
- WIDTH = 1: `all_q` == `any_q` == `out_q`, and `ones_q` is 1 bit equal to `out_q`.
- `ones_q` maximum value is WIDTH and never wraps, because CNT_W is sized to hold WIDTH.
- No X propagation from clk/rst into `out`. If clk/rst are X, the registered outputs may be X; the combinational output is unaffected.

Test Plan:
- WIDTH=1, positional 3-port instance. Apply a,b = 00, 01, 10, 11, each held 1 time unit, then check -> out = 0, 0, 0, 1.
- WIDTH=1, clocked. rst=1 for 2 cycles, then a=1, b=1 -> `out` = 1 immediately; after the 1st post-reset edge, `out_q`=1, `all_q`=1, `any_q`=1, `ones_q`=1, `valid_q`=1.
- WIDTH=8. a=8'hF0, b=8'h3C -> `out`=8'h30 at once; next edge `out_q`=8'h30, `all_q`=0, `any_q`=1, `ones_q`=2.
- WIDTH=8. a=8'hFF, b=8'hFF, then a=8'h00 -> registered outputs 8'hFF/1/1/8, then 8'h00/0/0/0 one cycle later.
- Mid-run reset. With `out_q`=8'h30, assert rst for 1 cycle while inputs change to 8'hFF/8'hFF -> `out` tracks 8'hFF immediately; all registered outputs are 0 and `valid_q`=0 after the reset edge; next edge gives `out_q`=8'hFF, `valid_q`=1.
- Random WIDTH=16, 1000 vectors -> `out` == a&b every step; `out_q` equals the previous cycle's a&b; `ones_q` == popcount(`out_q`).

Source files
------------

// File: rtl/and_n2t.sv
// Bitwise AND gate of parameterised width. It has a zero-latency combinational output and a
// registered copy of the result with reduction and population-count status outputs.
module and_n2t #(
   parameter int WIDTH = 1,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] out,
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] out_q,
   output logic             all_q,
   output logic             any_q,
   output logic [CNT_W-1:0] ones_q,
   output logic             valid_q
);

   logic [WIDTH-1:0] w_and;
   logic [CNT_W-1:0] w_ones;

   logic [WIDTH-1:0] r_out;
   logic             r_all;
   logic             r_any;
   logic [CNT_W-1:0] r_ones;
   logic             r_valid;

   // The combinational path must not depend on clk or rst, so a 3-port instance still works.
   assign w_and = a & b;
   assign out   = w_and;

   always_comb begin
      w_ones = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         w_ones = w_ones + CNT_W'(w_and[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out   <= '0;
         r_all   <= 1'b0;
         r_any   <= 1'b0;
         r_ones  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_out   <= w_and;
         r_all   <= &w_and;
         r_any   <= |w_and;
         r_ones  <= w_ones;
         r_valid <= 1'b1;
      end
   end

   assign out_q   = r_out;
   assign all_q   = r_all;
   assign any_q   = r_any;
   assign ones_q  = r_ones;
   assign valid_q = r_valid;

endmodule

// File: tb/tb_and_n2t.sv
// Scoreboard bench for and_n2t at widths 1, 8 and 16. The stimulus process pushes the expected
// registered results, and a monitor on the falling edge pops them and compares.
module tb_and_n2t;

   typedef struct {
      logic [15:0] q;
      logic        all_b;
      logic        any_b;
      int          ones;
      logic        valid;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   logic        a1, b1, out1, out_q1, all1, any1, ones1, val1;
   logic [7:0]  a8, b8, out8, out_q8;
   logic        all8, any8, val8;
   logic [3:0]  ones8;
   logic [15:0] a16, b16, out16, out_q16;
   logic        all16, any16, val16;
   logic [4:0]  ones16;

   exp_t q1[$], q8[$], q16[$];
   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   and_n2t #(.WIDTH(1)) u_w1 (
      .a(a1), .b(b1), .out(out1), .clk(clk), .rst(rst),
      .out_q(out_q1), .all_q(all1), .any_q(any1), .ones_q(ones1), .valid_q(val1));

   and_n2t #(.WIDTH(8)) u_w8 (
      .a(a8), .b(b8), .out(out8), .clk(clk), .rst(rst),
      .out_q(out_q8), .all_q(all8), .any_q(any8), .ones_q(ones8), .valid_q(val8));

   and_n2t #(.WIDTH(16)) u_w16 (
      .a(a16), .b(b16), .out(out16), .clk(clk), .rst(rst),
      .out_q(out_q16), .all_q(all16), .any_q(any16), .ones_q(ones16), .valid_q(val16));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Reference: result of an AND of width w, described by its value rather than gates.
   function automatic exp_t model(input logic [15:0] x, input int w, input logic r);
      exp_t        e;
      logic [15:0] mask;
      mask = (w == 16) ? 16'hFFFF : 16'((32'd1 << w) - 1);
      e.q = '0; e.all_b = 1'b0; e.any_b = 1'b0; e.ones = 0; e.valid = 1'b0;
      if (!r) begin
         e.q     = x;
         e.all_b = (x == mask);
         e.any_b = (x != 16'd0);
         for (int i = 0; i < w; i++) if (x[i]) e.ones++;
         e.valid = 1'b1;
      end
      return e;
   endfunction

   task automatic cycle(input logic r, input logic ia1, input logic ib1,
                        input logic [7:0] ia8, input logic [7:0] ib8,
                        input logic [15:0] ia16, input logic [15:0] ib16);
      rst = r; a1 = ia1; b1 = ib1; a8 = ia8; b8 = ib8; a16 = ia16; b16 = ib16;
      #1;
      chk("out_w1",  32'(out1),  32'(ia1 & ib1));
      chk("out_w8",  32'(out8),  32'(ia8 & ib8));
      chk("out_w16", 32'(out16), 32'(ia16 & ib16));
      @(posedge clk);
      q1.push_back(model(16'(ia1 & ib1), 1, r));
      q8.push_back(model(16'(ia8 & ib8), 8, r));
      q16.push_back(model(ia16 & ib16, 16, r));
      #2;
   endtask

   function automatic logic [15:0] rnd16();
      return 16'($urandom);
   endfunction

   // Monitor: registered outputs sampled on the falling edge after each capture.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("out_q_w1", 32'(out_q1), 32'(e.q));
            chk("all_q_w1", 32'(all1), 32'(e.all_b));
            chk("any_q_w1", 32'(any1), 32'(e.any_b));
            chk("ones_q_w1", 32'(ones1), 32'(e.ones));
            chk("valid_q_w1", 32'(val1), 32'(e.valid));
         end
         if (q8.size() > 0) begin
            e = q8.pop_front();
            chk("out_q_w8", 32'(out_q8), 32'(e.q));
            chk("all_q_w8", 32'(all8), 32'(e.all_b));
            chk("any_q_w8", 32'(any8), 32'(e.any_b));
            chk("ones_q_w8", 32'(ones8), 32'(e.ones));
            chk("valid_q_w8", 32'(val8), 32'(e.valid));
         end
         if (q16.size() > 0) begin
            e = q16.pop_front();
            chk("out_q_w16", 32'(out_q16), 32'(e.q));
            chk("all_q_w16", 32'(all16), 32'(e.all_b));
            chk("any_q_w16", 32'(any16), 32'(e.any_b));
            chk("ones_q_w16", 32'(ones16), 32'(e.ones));
            chk("valid_q_w16", 32'(val16), 32'(e.valid));
         end
      end
   end

   initial begin
      rst = 1'b1; a1 = 1'b0; b1 = 1'b0; a8 = '0; b8 = '0; a16 = '0; b16 = '0;
      @(posedge clk);
      #2;
      // Two reset cycles, then the single-bit gate with both inputs high.
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, rnd16(), rnd16());
      cycle(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, rnd16(), rnd16());
      cycle(1'b0, 1'b1, 1'b1, 8'hF0, 8'h3C, rnd16(), rnd16());
      // Truth table of the single-bit gate.
      cycle(1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF);
      cycle(1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 16'h0000, 16'hFFFF);
      cycle(1'b0, 1'b1, 1'b0, 8'hAA, 8'h55, 16'h8001, 16'h8001);
      cycle(1'b0, 1'b1, 1'b1, 8'hF0, 8'h3C, rnd16(), rnd16());
      // Reset mid-run while the inputs change: reset wins, and then FF/FF is captured.
      cycle(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF);
      cycle(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF);
      for (int i = 0; i < 1000; i++) begin
         logic [7:0] x8, y8;
         x8 = 8'($urandom);
         y8 = 8'($urandom);
         cycle(1'b0, 1'($urandom), 1'($urandom), x8, y8, rnd16(), rnd16() | rnd16());
      end
      repeat (2) @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(q1.size() + q8.size() + q16.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
